// File: rtl/kdw_reader.sv
// Depthwise kernel reader: fetches the K_DW*K_DW weights of one channel from
// the DW kernel RAM, assembles them into a flat kernel word and holds it
// until the consumer accepts it.

package irb_pkg;
    localparam int WG_W       = 8;
    localparam int KDW_N_ELEM = 80;
endpackage

module kdw_reader
    import irb_pkg::*;
#(
    parameter int K_DW = 3,
    parameter int CH_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CH_W-1:0]               ch,
    output logic [$clog2(KDW_N_ELEM)-1:0] ram_addr,
    output logic                          ram_rd,
    input  logic [WG_W-1:0]               ram_res,
    output logic [K_DW*K_DW*WG_W-1:0]     kern,
    output logic                          kern_valid,
    input  logic                          kern_ready,
    output logic                          busy,
    output logic                          err
);

    // state | meaning
    // IDLE  | waiting for start
    // READ  | issuing one RAM address per cycle
    // DRAIN | last read in flight, capturing final weight
    // HOLD  | kernel complete, waiting for kern_ready

    localparam int AW = $clog2(KDW_N_ELEM);
    localparam int NK = K_DW * K_DW;
    localparam int CW = (NK > 1) ? $clog2(NK) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] base;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          cap_en;
    logic [31:0]   base_full;
    logic          legal;
    logic          accept;
    logic          last_rd;

    // Legality is checked at 32 bits so an out-of-range channel cannot alias
    // into a legal address after truncation.
    always_comb begin
        base_full = 32'(ch) * 32'(NK);
        legal     = (base_full + 32'(NK) - 32'd1) <= 32'(KDW_N_ELEM - 1);
        accept    = (state == IDLE) && start && legal;
        last_rd   = (cnt == CW'(NK - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    if (last_rd) state_nxt = DRAIN;
            DRAIN:   state_nxt = HOLD;
            HOLD:    if (kern_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        ram_rd     = (state == READ);
        ram_addr   = (state == READ) ? (base + AW'(cnt)) : '0;
        busy       = (state != IDLE);
        kern_valid = (state == HOLD);
    end

    // Address counter, read-data capture pipeline and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            base   <= '0;
            cnt    <= '0;
            idx    <= '0;
            cap_en <= 1'b0;
            err    <= 1'b0;
            kern   <= '0;
        end else begin
            err    <= (state == IDLE) && start && !legal;
            cap_en <= (state == READ);
            idx    <= cnt;
            if (accept) begin
                base <= AW'(base_full);
                cnt  <= '0;
            end else if ((state == READ) && !last_rd) begin
                cnt <= cnt + 1'b1;
            end
            if (cap_en) kern[int'(idx)*WG_W +: WG_W] <= ram_res;
        end
    end

endmodule

// File: tb/tb_kdw_reader.sv
// Bench for kdw_reader: RAM model with mem[a]=a, scoreboard queues for
// addresses, kernels and latency, and a negedge monitor that checks them.

module tb_kdw_reader;
    import irb_pkg::*;

    localparam int K_DW = 3;
    localparam int NK   = K_DW * K_DW;
    localparam int AW   = $clog2(KDW_N_ELEM);
    localparam int KW   = NK * WG_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    ch;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [WG_W-1:0] ram_res;
    logic [KW-1:0] kern;
    logic          kern_valid;
    logic          kern_ready;
    logic          busy;
    logic          err;

    kdw_reader #(.K_DW(K_DW), .CH_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .ch(ch),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_res(ram_res),
        .kern(kern), .kern_valid(kern_valid), .kern_ready(kern_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, contents equal to address
    always @(posedge clk) ram_res <= WG_W'(ram_addr);

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n++;

    logic [AW-1:0] addr_q[$];
    logic [KW-1:0] kern_q[$];
    int            lat_q[$];
    bit            err_exp = 1'b0;
    logic          kv_prev = 1'b0;

    task automatic chk(string name, logic [KW-1:0] act, logic [KW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] kexp(int b);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < NK; i++) k[i*WG_W +: WG_W] = WG_W'(b + i);
        return k;
    endfunction

    // Monitor: address stream, idle address, err pulse, kernel and latency
    always @(negedge clk) begin
        if (ram_rd) begin
            if (addr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ram_rd: got 1 want 0 (addr %0d)", ram_addr);
            end else begin
                chk("ram_addr", KW'(ram_addr), KW'(addr_q.pop_front()));
            end
        end else begin
            chk("addr_idle", KW'(ram_addr), '0);
        end
        chk("err", KW'(err), KW'(err_exp));
        if (kern_valid && !kv_prev) begin
            if (kern_q.size() == 0) begin
                total++; bad++;
                $display("FAIL kern_valid: got 1 want 0 (no fetch pending)");
            end else begin
                chk("kern", kern, kern_q.pop_front());
                chk("latency", KW'(edge_n), KW'(lat_q.pop_front()));
            end
        end
        kv_prev = kern_valid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One fetch; poke >= 0 re-asserts start with another ch during READ.
    // early_ready holds kern_ready high before the kernel is ready.
    task automatic fetch(int c, int hold_cycles, bit early_ready, int poke);
        int b;
        b = c * NK;
        for (int i = 0; i < NK; i++) addr_q.push_back(AW'(b + i));
        kern_q.push_back(kexp(b));
        start = 1'b1;
        ch = 8'(c);
        if (early_ready) kern_ready = 1'b1;
        tick;
        lat_q.push_back(edge_n + NK + 1);
        start = 1'b0;
        if (early_ready) begin
            for (int k = 0; k < 40 && busy; k++) tick;
            kern_ready = 1'b0;
            chk("b2b_busy", KW'(busy), '0);
            return;
        end
        for (int k = 0; k < 40 && !kern_valid; k++) begin
            if (k == poke) begin
                start = 1'b1;
                ch = 8'(c + 3);
            end
            tick;
            start = 1'b0;
        end
        chk("kv_seen", KW'(kern_valid), KW'(1));
        for (int h = 0; h < hold_cycles; h++) begin
            chk("hold_kv", KW'(kern_valid), KW'(1));
            chk("hold_busy", KW'(busy), KW'(1));
            chk("hold_kern", kern, kexp(b));
            tick;
        end
        kern_ready = 1'b1;
        tick;
        kern_ready = 1'b0;
        chk("done_busy", KW'(busy), '0);
        chk("done_kv", KW'(kern_valid), '0);
        chk("kern_retained", kern, kexp(b));
    endtask

    task automatic bad_start(int c);
        start = 1'b1;
        ch = 8'(c);
        tick;
        err_exp = 1'b1;
        start = 1'b0;
        chk("bad_busy", KW'(busy), '0);
        tick;
        err_exp = 1'b0;
        chk("bad_busy2", KW'(busy), '0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ch = '0; kern_ready = 1'b0;
        repeat (2) tick;
        chk("rst_kv", KW'(kern_valid), '0);
        chk("rst_busy", KW'(busy), '0);
        chk("rst_kern", kern, '0);
        chk("rst_rd", KW'(ram_rd), '0);
        rst = 1'b0;
        tick;

        fetch(2, 5, 1'b0, -1);   // addresses 18..26, held 5 cycles
        bad_start(8);            // base 72, last 80 > 79
        bad_start(255);          // large ch must not alias after truncation
        fetch(7, 1, 1'b0, -1);   // highest legal channel: 63..71
        fetch(2, 1, 1'b0, 3);    // second start during READ is ignored

        // Reset in the cycle that issues cnt=4; start/ready with rst lose
        for (int i = 0; i < 5; i++) addr_q.push_back(AW'(9 + i));
        start = 1'b1; ch = 8'd1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        rst = 1'b1; start = 1'b1; ch = 8'd0; kern_ready = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0; kern_ready = 1'b0;
        chk("midrst_kv", KW'(kern_valid), '0);
        chk("midrst_busy", KW'(busy), '0);
        chk("midrst_kern", kern, '0);
        chk("midrst_rd", KW'(ram_rd), '0);
        fetch(0, 2, 1'b0, -1);   // slots 0..8

        fetch(4, 0, 1'b1, -1);   // ready already high when kern_valid rises
        fetch(3, 0, 1'b1, -1);   // started the cycle after handshake

        repeat (3) tick;
        chk("addr_q_empty", KW'(addr_q.size()), '0);
        chk("kern_q_empty", KW'(kern_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
